// File: rtl/seq_reset_pkg.sv
// Shared types and helpers for the sequence-unlocked reset controller.
package seq_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MATCH   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam int ELEM_MAX_W   = 32;
  localparam int SEQ_MAX_BITS = 16 * ELEM_MAX_W;

  // Element 0 sits in the MSBs of the packed sequence; callers zero-extend seq and truncate the result.
  function automatic logic [ELEM_MAX_W-1:0] seq_elem(
    input logic [SEQ_MAX_BITS-1:0] seq,
    input int unsigned             idx,
    input int unsigned             len,
    input int unsigned             dw
  );
    int unsigned shift;
    if (idx < len) begin
      shift = (len - 32'd1 - idx) * dw;
    end else begin
      shift = 32'd0;
    end
    return ELEM_MAX_W'(seq >> shift);
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable saturating down-counter reused for gap, pulse and holdoff timing.
module seq_gap_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != {W{1'b0}})) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/seq_reset_ctrl.sv
// Symbol-sequence detector that issues a force_reset pulse followed by a lockout.
// Define SEQ_RESET_STICKY_EN to hold force_reset until reset_ack instead of a fixed pulse.
module seq_reset_ctrl
  import seq_reset_pkg::*;
#(
  parameter int                          DATA_W         = 8,
  parameter int                          SEQ_LEN        = 4,
  parameter logic [SEQ_LEN*DATA_W-1:0]   SEQ            = {8'hAA, 8'h55, 8'hA5, 8'h5A},
  parameter int                          GAP_MAX        = 16,
  parameter int                          PULSE_CYCLES   = 4,
  parameter int                          HOLDOFF_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         data_valid,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         reset_ack,
  output logic                         force_reset,
  output logic [$clog2(SEQ_LEN+1)-1:0] match_idx,
  output logic                         busy
);

  localparam int IDX_W   = $clog2(SEQ_LEN + 1);
  localparam int CNT_MAX = (GAP_MAX > PULSE_CYCLES)
                         ? ((GAP_MAX > HOLDOFF_CYCLES) ? GAP_MAX : HOLDOFF_CYCLES)
                         : ((PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [SEQ_MAX_BITS-1:0] SEQ_EXT    = SEQ_MAX_BITS'(SEQ);
  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0]        GAP_LOAD   = CNT_W'(GAP_MAX - 1);
  localparam logic [CNT_W-1:0]        PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   match_idx_q;
  logic               force_reset_q;
  logic               busy_q;

  logic [DATA_W-1:0]  cur_elem;
  logic [DATA_W-1:0]  first_elem;
  logic               hit_cur;
  logic               hit_first;
  logic               at_last;
  logic               pulse_done;
  logic               tmr_load;
  logic               tmr_dec;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_zero;

  // Symbol compare and exit-condition decode shared by the FSM and the timer.
  always_comb begin
    cur_elem   = DATA_W'(seq_elem(SEQ_EXT, 32'(match_idx_q), SEQ_LEN, DATA_W));
    first_elem = DATA_W'(seq_elem(SEQ_EXT, 32'd0, SEQ_LEN, DATA_W));
    hit_cur    = data_valid && (data_in == cur_elem);
    hit_first  = data_valid && (data_in == first_elem);
    at_last    = (match_idx_q == LAST_IDX);
`ifdef SEQ_RESET_STICKY_EN
    pulse_done = reset_ack;
`else
    pulse_done = reset_ack || tmr_zero;
`endif
  end

  // Each timed phase reloads the timer on entry; every valid symbol in MATCH restarts the gap window.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = GAP_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (enable && hit_first) begin
          tmr_load = 1'b1;
        end else begin
          tmr_load = 1'b0;
        end
      end
      ST_MATCH: begin
        if (!enable) begin
          tmr_load = 1'b0;
        end else if (hit_cur && at_last) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end else if (data_valid) begin
          tmr_load = 1'b1;
        end else begin
          tmr_dec  = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (pulse_done) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end else begin
          tmr_dec  = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        tmr_dec = 1'b1;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  seq_gap_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Main FSM with registered outputs; a valid symbol in MATCH is never also an idle cycle, so a final match beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      match_idx_q   <= {IDX_W{1'b0}};
      force_reset_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && hit_first) begin
            state_q     <= ST_MATCH;
            match_idx_q <= IDX_W'(1);
          end else begin
            match_idx_q <= {IDX_W{1'b0}};
          end
        end
        ST_MATCH: begin
          if (!enable) begin
            state_q     <= ST_IDLE;
            match_idx_q <= {IDX_W{1'b0}};
          end else if (hit_cur && at_last) begin
            state_q       <= ST_ASSERT;
            match_idx_q   <= {IDX_W{1'b0}};
            force_reset_q <= 1'b1;
            busy_q        <= 1'b1;
          end else if (hit_cur) begin
            match_idx_q <= match_idx_q + IDX_W'(1);
          end else if (hit_first) begin
            match_idx_q <= IDX_W'(1);
          end else if (data_valid || tmr_zero) begin
            state_q     <= ST_IDLE;
            match_idx_q <= {IDX_W{1'b0}};
          end
        end
        ST_ASSERT: begin
          match_idx_q <= {IDX_W{1'b0}};
          if (pulse_done) begin
            state_q       <= ST_HOLDOFF;
            force_reset_q <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          match_idx_q <= {IDX_W{1'b0}};
          if (tmr_zero) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          match_idx_q   <= {IDX_W{1'b0}};
          force_reset_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign force_reset = force_reset_q;
  assign match_idx   = match_idx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_seq_reset_ctrl.sv
// Directed scoreboard bench for seq_reset_ctrl with default parameters.
module tb_seq_reset_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       data_valid;
  logic [7:0] data_in;
  logic       reset_ack;
  logic       force_reset;
  logic [2:0] match_idx;
  logic       busy;

  logic [4:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  string      scen;

  seq_reset_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .reset_ack   (reset_ack),
    .force_reset (force_reset),
    .match_idx   (match_idx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops the oldest expectation and compares it against {force_reset, busy, match_idx}.
  task automatic check();
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {force_reset, busy, match_idx};
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed %b but no expectation queued", scen, obs);
    end
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed fr/busy/idx=%b expected %b", scen, obs, exp);
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ack,
                      input logic efr, input logic ebusy, input logic [2:0] eidx);
    data_valid = v;
    data_in    = d;
    reset_ack  = ack;
    exp_q.push_back({efr, ebusy, eidx});
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic idle(input int n, input logic efr, input logic ebusy, input logic [2:0] eidx);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, efr, ebusy, eidx);
  endtask

  task automatic send_seq();
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd3);
    step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 3'd0);
  endtask

  // Rest of the pulse, the 8-cycle lockout (optionally replaying the sequence into it), then idle.
  task automatic pulse_tail(input logic replay);
`ifdef SEQ_RESET_STICKY_EN
    idle(6, 1'b1, 1'b1, 3'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0);
`else
    idle(3, 1'b1, 1'b1, 3'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0);
`endif
    if (replay) begin
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 3'd0);
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 3'd0);
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd0);
      step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 3'd0);
      idle(3, 1'b0, 1'b1, 3'd0);
    end else begin
      idle(7, 1'b0, 1'b1, 3'd0);
    end
    idle(1, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    reset_ack  = 1'b0;

    scen = "reset";
    exp_q.push_back(5'b00000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check();
    rst_n  = 1'b1;
    enable = 1'b1;

    scen = "basic_seq";
    idle(2, 1'b0, 1'b0, 3'd0);
    send_seq();
    enable = 1'b0;
    pulse_tail(1'b0);
    enable = 1'b1;

    scen = "overlap";
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd3);
    step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 3'd0);
    pulse_tail(1'b0);

    scen = "gap_timeout";
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 3'd2);
    idle(15, 1'b0, 1'b0, 3'd2);
    idle(1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(2, 1'b0, 1'b0, 3'd0);

    scen = "gap_15_ok";
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd1);
    idle(15, 1'b0, 1'b0, 3'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

    scen = "enable_low_match";
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 3'd2);
    enable = 1'b0;
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd0);
    enable = 1'b1;

    scen = "holdoff_ignore";
    send_seq();
    pulse_tail(1'b1);

    scen = "ack_idle";
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 3'd1);
    step(1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 3'd0);

`ifdef SEQ_RESET_STICKY_EN
    scen = "sticky_ack";
    send_seq();
    idle(14, 1'b1, 1'b1, 3'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    idle(7, 1'b0, 1'b1, 3'd0);
    idle(1, 1'b0, 1'b0, 3'd0);
`else
    scen = "early_ack";
    send_seq();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    idle(7, 1'b0, 1'b1, 3'd0);
    idle(1, 1'b0, 1'b0, 3'd0);
`endif

    scen = "async_reset";
    send_seq();
    idle(1, 1'b1, 1'b1, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(5'b00000);
    check();
    exp_q.push_back(5'b00000);
    @(posedge clk);
    #1;
    check();
    rst_n = 1'b1;
    idle(6, 1'b0, 1'b0, 3'd0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd1);
    idle(1, 1'b0, 1'b0, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
